// File: rtl/fe_fb_arb.sv
// Fill-buffer request arbiter between the fetch demand path (DM) and the
// instruction prefetcher (PF).
// - Grants one requester per cycle onto the single fill-buffer request port.
// - Tags each request with a free slot id.
// - Routes out-of-order fill-buffer responses back to the requester that owns the slot.
// - A flush kills every outstanding slot: its response is later absorbed.
//
// Ports:
//   clk_i, reset_ni                       clock, async active-low reset
//   dm_req_valid_i/addr_i, dm_req_ready_o demand request handshake
//   pf_req_valid_i/addr_i, pf_req_ready_o prefetch request handshake
//   fb_req_valid_o/addr_o/id_o, fb_req_ready_i   request to fill buffer
//   fb_rsp_valid_i/id_i/data_i            response from fill buffer
//   dm_rsp_valid_o, pf_rsp_valid_o, rsp_data_o   routed response
//   flush_i                               kill all outstanding transactions
//   outst_cnt_o                           number of busy slots
//   err_bad_id_o                          sticky: response to a non-busy slot
module fe_fb_arb #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MAX_OUTST  = 4,
  parameter int unsigned STARVE_LIM = 3,
  localparam int unsigned IDW       = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              dm_req_valid_i,
  input  logic [ADDR_W-1:0] dm_req_addr_i,
  output logic              dm_req_ready_o,
  input  logic              pf_req_valid_i,
  input  logic [ADDR_W-1:0] pf_req_addr_i,
  output logic              pf_req_ready_o,
  output logic              fb_req_valid_o,
  output logic [ADDR_W-1:0] fb_req_addr_o,
  output logic [IDW-1:0]    fb_req_id_o,
  input  logic              fb_req_ready_i,
  input  logic              fb_rsp_valid_i,
  input  logic [IDW-1:0]    fb_rsp_id_i,
  input  logic [DATA_W-1:0] fb_rsp_data_i,
  output logic              dm_rsp_valid_o,
  output logic              pf_rsp_valid_o,
  output logic [DATA_W-1:0] rsp_data_o,
  input  logic              flush_i,
  output logic [IDW:0]      outst_cnt_o,
  output logic              err_bad_id_o
);

  localparam int unsigned SW = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;
  localparam logic [SW-1:0] StarveMax = SW'(STARVE_LIM);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [IDW-1:0]         id_q, id_d;
  logic [MAX_OUTST-1:0]   busy_q, busy_d;
  logic [MAX_OUTST-1:0]   owner_q, owner_d;   // 1 = PF owns the slot
  logic [MAX_OUTST-1:0]   killed_q, killed_d;
  logic [SW-1:0]          starve_q, starve_d;
  logic                   err_q, err_d;
  logic [IDW:0]           cnt_q, cnt_d;

  logic                   has_free;
  logic [IDW-1:0]         free_id;
  logic                   accept, pf_win, dm_gnt, pf_gnt;

  // Lowest free slot, from the start-of-cycle busy vector so a slot freed
  // this cycle is not handed out until the next one.
  always_comb begin
    has_free = 1'b0;
    free_id  = '0;
    for (int i = int'(MAX_OUTST) - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        has_free = 1'b1;
        free_id  = IDW'(i);
      end
    end
  end

  always_comb begin
    accept = ((state_q == StIdle) || fb_req_ready_i) && has_free && !flush_i;
    pf_win = pf_req_valid_i && (!dm_req_valid_i || (starve_q >= StarveMax));
    dm_gnt = accept && dm_req_valid_i && !pf_win;
    pf_gnt = accept && pf_win;
  end

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    id_d           = id_q;
    busy_d         = busy_q;
    owner_d        = owner_q;
    killed_d       = killed_q;
    starve_d       = starve_q;
    err_d          = err_q;
    cnt_d          = '0;
    dm_rsp_valid_o = 1'b0;
    pf_rsp_valid_o = 1'b0;

    // Kill first so that a slot freed in the same cycle ends up clean.
    if (flush_i) begin
      killed_d = killed_q | busy_q;
    end

    if (fb_rsp_valid_i) begin
      if (busy_q[fb_rsp_id_i]) begin
        busy_d[fb_rsp_id_i]   = 1'b0;
        killed_d[fb_rsp_id_i] = 1'b0;
        if (!killed_q[fb_rsp_id_i] && !flush_i) begin
          if (owner_q[fb_rsp_id_i]) begin
            pf_rsp_valid_o = 1'b1;
          end else begin
            dm_rsp_valid_o = 1'b1;
          end
        end
      end else begin
        err_d = 1'b1;
      end
    end

    if (dm_gnt || pf_gnt) begin
      busy_d[free_id]   = 1'b1;
      owner_d[free_id]  = pf_gnt;
      killed_d[free_id] = 1'b0;
      addr_d            = pf_gnt ? pf_req_addr_i : dm_req_addr_i;
      id_d              = free_id;
    end

    unique case (state_q)
      StIdle: if (dm_gnt || pf_gnt) state_d = StSend;
      StSend: if (fb_req_ready_i && !(dm_gnt || pf_gnt)) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (flush_i || pf_gnt || !pf_req_valid_i) begin
      starve_d = '0;
    end else if (dm_gnt && (starve_q != StarveMax)) begin
      starve_d = starve_q + SW'(1);
    end

    for (int i = 0; i < int'(MAX_OUTST); i++) begin
      cnt_d = cnt_d + (IDW + 1)'(busy_d[i]);
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      id_q     <= '0;
      busy_q   <= '0;
      owner_q  <= '0;
      killed_q <= '0;
      starve_q <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      id_q     <= id_d;
      busy_q   <= busy_d;
      owner_q  <= owner_d;
      killed_q <= killed_d;
      starve_q <= starve_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dm_req_ready_o = dm_gnt;
  assign pf_req_ready_o = pf_gnt;
  assign fb_req_valid_o = (state_q == StSend);
  assign fb_req_addr_o  = addr_q;
  assign fb_req_id_o    = id_q;
  assign rsp_data_o     = fb_rsp_data_i;
  assign outst_cnt_o    = cnt_q;
  assign err_bad_id_o   = err_q;

endmodule

// File: doc/fe_fb_arb.md
Name: fe_fb_arb

Overview:
- Arbitrates the single fill-buffer request port between two requesters: the fetch demand path (DM) and an instruction prefetcher (PF).
- Allocates a transaction id per request from a slot table and routes out-of-order fill-buffer responses back to the owning requester.
- Supports a flush that kills all outstanding transactions. Sits between the fetch control/prefetch logic and the fill buffer.

Parameters:
ADDR_W, 32, physical address width (matches t_paddr)
DATA_W, 32, response instruction width
MAX_OUTST, 4, outstanding transaction slots; id width IDW = $clog2(MAX_OUTST)
STARVE_LIM, 3, consecutive PF losses before PF is forced to win

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
dm_req_valid  in  1  demand request valid
dm_req_addr  in  ADDR_W  demand address
dm_req_ready  out  1  demand request accepted this cycle
pf_req_valid  in  1  prefetch request valid
pf_req_addr  in  ADDR_W  prefetch address
pf_req_ready  out  1  prefetch request accepted this cycle
fb_req_valid  out  1  request to fill buffer
fb_req_addr  out  ADDR_W  address to fill buffer
fb_req_id  out  IDW  slot id
fb_req_ready  in  1  fill buffer accepts request
fb_rsp_valid  in  1  fill-buffer response valid
fb_rsp_id  in  IDW  response slot id
fb_rsp_data  in  DATA_W  response instruction
dm_rsp_valid  out  1  response for demand
pf_rsp_valid  out  1  response for prefetch
rsp_data  out  DATA_W  response data, shared by both requesters
flush  in  1  kill all outstanding transactions
outst_cnt  out  IDW+1  count of busy slots
err_bad_id  out  1  sticky: response to a non-busy slot

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- On reset:
  - State is IDLE and all slots are free.
  - Starvation counter is 0.
  - All outputs are 0, including err_bad_id and outst_cnt.
- FSM states: IDLE and SEND.
  - IDLE: fb_req_valid=0.
  - SEND: fb_req_valid=1. fb_req_addr and fb_req_id are registered and held stable until fb_req_ready.
- Accept condition: (state==IDLE or (SEND and fb_req_ready)) and a free slot exists (sampled at start of cycle) and ~flush.
  - When accept holds and a requester is valid: assert that requester's ready (exactly one), capture address, allocate the lowest free slot, set owner, next state SEND.
  - In SEND with fb_req_ready and no accept: next state IDLE.
  - This gives back-to-back issue, one request per cycle max.
- Arbitration:
  - DM wins by default.
  - PF wins if only PF is valid, or if the starvation counter is >= STARVE_LIM.
  - Counter: increments (saturating) when PF is valid and DM is granted; clears when PF is granted or PF is not valid.
- Ready timing: dm_req_ready/pf_req_ready are combinational on the valid inputs. Requesters must hold valid and addr until ready.
- Slot table: per slot, busy, owner (DM/PF) and killed bits.
  - Slot is set busy on allocation.
  - Slot is freed on fb_rsp_valid with matching id.
  - A slot freed in cycle N is allocatable in N+1 (no same-cycle reuse).
- Full: all slots busy -> no grants. SEND still completes its pending handshake.
- Response routing: on fb_rsp_valid to a busy, non-killed slot, pulse dm_rsp_valid or pf_rsp_valid per owner in the same cycle (combinational). rsp_data = fb_rsp_data.
- Killed-slot response: slot freed, no rsp_valid.
- Bad id: response to a non-busy slot sets err_bad_id (sticky until reset) and is otherwise ignored.
- Flush:
  - Sets killed on every busy slot, including the slot in SEND (a request cannot be retracted, so it completes with killed=1).
  - Blocks new accepts that cycle.
  - Clears the starvation counter.
  - Flush and fb_rsp_valid in the same cycle: response is dropped, slot freed.
- outst_cnt is the registered popcount of busy slots.
- Reset mid-operation: everything returns to reset values immediately (async). Responses arriving after reset are counted as bad ids.

Test Plan:
1. DM only, addr 0x0,0x4,0x8; fb_req_ready=1 always -> fb_req_id 0,1,2 on consecutive cycles; responses ids 1,0,2 -> three dm_rsp_valid pulses in that order with matching data; outst_cnt ends at 0.
2. DM and PF both valid continuously, STARVE_LIM=3 -> grant pattern DM,DM,DM,PF repeating; PF never starves.
3. Issue 4 requests, withhold responses -> 5th request sees ready=0 and outst_cnt=4. Respond id 2 in cycle N -> 5th request accepted in cycle N+1 with id 2.
4. fb_req_ready held low 5 cycles -> fb_req_addr/id stable; no further dm/pf_req_ready.
5. Two busy slots (DM id0, PF id1), flush pulse, then responses for id0 and id1 -> no rsp_valid, slots freed, err_bad_id=0.
6. Response to a free id 3 -> err_bad_id=1, held until reset_n low; reset_n low asynchronously mid-SEND -> fb_req_valid=0 immediately.
